// File: rtl/pipelined_addsub_pkg.sv
// Shared constants for the ALU add/sub datapath: flag bit positions,
// mode encoding and the default operand width.
package alu_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int NUM_FLAGS     = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;
endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
interface pipelined_addsub_if #(
  parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              a;
  logic [WIDTH-1:0]              b;
  logic                          carry_in;
  logic                          sub;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              result;
  logic [alu_pkg::NUM_FLAGS-1:0] flags;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/pipelined_addsub_cla_slice.sv
// Combinational carry-lookahead slice: group generate/propagate chain the
// carries between GROUP-bit groups; bits inside a group use local carries.
module cla_slice #(
  parameter int W     = 8,
  parameter int GROUP = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  localparam int NG = W / GROUP;

  logic [W-1:0] g, p;
  logic [W:0]   c;
  logic         gg, pp;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        pp = pp & p[j*GROUP+i];
        if (i < GROUP - 1)
          c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
      end
      // group carry comes from G/P, not from the last in-group carry
      c[(j+1)*GROUP] = gg | (pp & c[j*GROUP]);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub: one CLA slice per stage, carry registered between
// stages, elastic valid/ready pipeline, N/Z/V/C flags from the last stage.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic              clock,
  input  logic              clear,
  pipelined_addsub_if.slave bus
);
  localparam int SLICE = (STAGES > 0) ? WIDTH / STAGES : 1;
  localparam int LAST  = (STAGES > 0) ? STAGES - 1 : 0;

  if (WIDTH <= 0 || STAGES <= 0 || GROUP <= 0) begin : g_bad_zero
    $error("pipelined_addsub: WIDTH, STAGES and GROUP must be nonzero");
  end else if ((WIDTH % STAGES) != 0 || (SLICE % GROUP) != 0) begin : g_bad_div
    $error("pipelined_addsub: STAGES must divide WIDTH and GROUP must divide WIDTH/STAGES");
  end

  logic [STAGES-1:0]            vld, co_r, cm_r;
  logic [STAGES-1:0][WIDTH-1:0] a_r, b_r, res_r;

  logic [STAGES:0]              en;
  logic [STAGES-1:0]            up_vld, cin_s, so, sm;
  logic [STAGES-1:0][WIDTH-1:0] up_a, up_b, up_res, nres;
  logic [STAGES-1:0][SLICE-1:0] sa, sb, ss;
  logic [WIDTH-1:0]             b_eff;
  logic                         c_eff;
  logic [NUM_FLAGS-1:0]         flags_c;
  logic                         unused_bits;

  always_comb begin
    b_eff = (op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;
    c_eff = (op_e'(bus.sub) == OP_SUB) ? 1'b1 : bus.carry_in;
    // a stage can load when empty or when its occupant moves on
    en         = '0;
    en[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      en[k] = !vld[k] || en[k+1];
    up_vld[0] = bus.in_valid;
    up_a[0]   = bus.a;
    up_b[0]   = b_eff;
    up_res[0] = '0;
    cin_s[0]  = c_eff;
    for (int k = 1; k < STAGES; k++) begin
      up_vld[k] = vld[k-1];
      up_a[k]   = a_r[k-1];
      up_b[k]   = b_r[k-1];
      up_res[k] = res_r[k-1];
      cin_s[k]  = co_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sa[k] = up_a[k][k*SLICE +: SLICE];
      sb[k] = up_b[k][k*SLICE +: SLICE];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.W(SLICE), .GROUP(GROUP)) u_slice (
      .a    (sa[k]),
      .b    (sb[k]),
      .cin  (cin_s[k]),
      .sum  (ss[k]),
      .cout (so[k]),
      .cmsb (sm[k])
    );
  end

  always_comb begin
    nres = up_res;
    for (int k = 0; k < STAGES; k++)
      nres[k][k*SLICE +: SLICE] = ss[k];
  end

  // payload only loads with a valid op, so outputs stay 0 after clear
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vld   <= '0;
      co_r  <= '0;
      cm_r  <= '0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld[k] <= up_vld[k];
          if (up_vld[k]) begin
            a_r[k]   <= up_a[k];
            b_r[k]   <= up_b[k];
            res_r[k] <= nres[k];
            co_r[k]  <= so[k];
            cm_r[k]  <= sm[k];
          end
        end
      end
    end
  end

  always_comb begin
    flags_c = '0;
    if (vld[LAST]) begin
      flags_c[FLAG_C] = co_r[LAST];
      flags_c[FLAG_V] = co_r[LAST] ^ cm_r[LAST];
      flags_c[FLAG_Z] = (res_r[LAST] == '0);
      flags_c[FLAG_N] = res_r[LAST][WIDTH-1];
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = vld[LAST];
  assign bus.result    = res_r[LAST];
  assign bus.flags     = flags_c;

  // operand bits already consumed by earlier slices have no reader
  assign unused_bits = ^{a_r, b_r, cm_r};
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed + random bench for pipelined_addsub with a scoreboard queue.
module tb_pipelined_addsub;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    int           cyc;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   lat_chk = 1'b1;
  exp_t sb[$];

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .STAGES(S), .GROUP(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // independent reference: 33-bit sum, signed overflow from operand signs
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub, input int c);
    exp_t e;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
    e.res = s[W-1:0];
    e.fl  = {s[W-1], (s[W-1:0] == '0), (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]), s[W]};
    e.cyc = c;
    return e;
  endfunction

  // output monitor: scoreboard pop, latency and stall stability
  logic         stalled = 1'b0;
  logic [W-1:0] held_res;
  logic [3:0]   held_fl;
  always @(negedge clock) begin
    if (clear) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_result", bus.result, held_res);
        chk("stall_flags", bus.flags, held_fl);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("unexpected_output", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("flags", bus.flags, e.fl);
          if (lat_chk) chk("latency", cyc - e.cyc, S);
        end
      end
      stalled  = bus.out_valid && !bus.out_ready;
      held_res = bus.result;
      held_fl  = bus.flags;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sub, input logic [W-1:0] er, input logic [3:0] ef);
    bit ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.carry_in = ci; bus.sub = sub;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    chk("accept", ok, 1);
    if (ok) begin
      e.res = er; e.fl = ef; e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic issue_rand();
    logic [W-1:0] a, b;
    logic ci, sub;
    exp_t e;
    a = $urandom(); b = $urandom(); ci = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    e = model(a, b, ci, sub, 0);
    issue(a, b, ci, sub, e.res, e.fl);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    chk("drain", done, 1);
    repeat (8) @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    exp_t e;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.carry_in = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    clear = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);
    @(posedge clock); #1;

    // directed corner cases, flags are {N,Z,V,C}
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0101);
    bus.in_valid = 1'b0;
    drain();
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b0011);
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b1010);
    issue(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 4'b0101);
    issue(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 4'b0000);
    issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1000);
    bus.in_valid = 1'b0;
    drain();

    // back-to-back random stream
    for (int i = 0; i < 8; i++) issue_rand();
    bus.in_valid = 1'b0;
    drain();

    // full stall: only S ops fit, then random back-pressure
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom(); bus.b = $urandom();
      bus.carry_in = 1'($urandom_range(0, 1)); bus.sub = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b, bus.carry_in, bus.sub, cyc));
        acc++;
      end
      @(posedge clock); #1;
    end
    chk("stall_accepts", acc, S);
    chk("stall_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("in_ready_comb", bus.in_ready, 1);
    @(negedge clock);
    if (bus.in_ready) sb.push_back(model(bus.a, bus.b, bus.carry_in, bus.sub, cyc));
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    drain();
    lat_chk = 1'b1;

    // clear with 3 ops in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_rand();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("pre_clear_valid", bus.out_valid, 1);
    clear = 1'b1;
    #1;
    chk("clear_out_valid", bus.out_valid, 0);
    chk("clear_result", bus.result, 0);
    chk("clear_flags", bus.flags, 0);
    sb.delete();
    @(posedge clock); #1;
    clear = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_clear_in_ready", bus.in_ready, 1);
    chk("post_clear_out_valid", bus.out_valid, 0);
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 0);
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, e.res, e.fl);
    bus.in_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
